v_rams_dp_be: RTL and testbench
===============================

Name: v_rams_dp_be

Overview:
Parametrised true dual-port synchronous RAM, single clock. Both ports read and write, each with its own enable and per-byte write enables. Adds a selectable read-during-write mode, an optional output pipeline register, read-valid strobes and collision detection. Drop-in successor for fixed 64x16 dual-port RAMs in datapath buffers that need byte-granular writes from either side.

Parameters:
DATA_W, 16, word width in bits; must be an integer multiple of BYTE_W (elaboration error otherwise).
BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
ADDR_W, 6, address width; depth = 2**ADDR_W.
WRITE_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  port A enable.
wea  in  NB  port A byte write enables, qualified by ena.
addra  in  ADDR_W  port A address.
dia  in  DATA_W  port A write data.
doa  out  DATA_W  port A read data.
vlda  out  1  port A read-data valid.
enb, web, addrb, dib, dob, vldb: same as port A, for port B.
coll  out  1  collision pulse.

Behaviour:
- Reset: rst_n low asynchronously clears doa, dob, vlda, vldb, coll and all pipeline stages to 0. Memory array is not cleared. Writes are suppressed while rst_n is low.
- Port enabled at edge k: byte lane i written with dia[i*BYTE_W +: BYTE_W] when wea[i]=1. A read is launched for every enabled cycle.
- Latency: OUT_REG=0 puts data on doa after edge k, with vlda=1 for that cycle. OUT_REG=1 delays both data and valid one further edge.
- Port disabled: no read or write. doa holds its last value. vlda=0 for the corresponding cycle.
- Same-port read during write (any wea bit set):
  - READ_FIRST: doa = contents before the write.
  - WRITE_FIRST: doa = merged word; written lanes new, others old.
  - NO_CHANGE: doa holds its previous value and vlda=0 for that cycle.
- Cross-port, same address, same edge:
  - Read against write: the reader sees the pre-write contents in all modes.
  - Write/write on the same lane: port A wins. Non-overlapping lanes from both ports are merged.
- coll: asserts when ena & enb & (addra==addrb) & (|wea | |web) at edge k. It is a one-cycle pulse, aligned with the OUT_REG=0 data timing, i.e. driven after edge k. It is not delayed by OUT_REG.
- Reset deasserted mid-stream: first valid output is the first enabled cycle after release. No stale vld.
- Addresses wrap naturally; no out-of-range case exists.
- Each port's read datapath is independent. No throughput limit: one access per port per cycle.

Decomposition:
- Shared package v_rams_pkg:
  - WRITE_MODE constants WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2.
  - Function computing NB from DATA_W/BYTE_W.
- Sub-module v_rams_oreg: the per-port optional output stage (data + valid, reset, OUT_REG bypass), instantiated twice.
- Array, write merging and collision logic stay in the top module.

Test Plan:
- Byte write: reset, A writes 0xBEEF to addr 5 (wea=11), then wea=01 with 0x0012 -> A reads 0xBE12 at addr 5 one cycle after the read edge, with vlda=1.
- Read-during-write modes: addr 3 holds 0x1111; A writes 0x2222 with ena=1.
  - READ_FIRST -> doa=0x1111.
  - WRITE_FIRST -> doa=0x2222.
  - NO_CHANGE -> doa unchanged and vlda=0.
  - In all three modes, a next-cycle read returns 0x2222.
- Collisions: same edge, A writes 0xAAAA and B writes 0x5555, both to addr 9 with full enables -> coll=1 for one cycle; a later read of addr 9 gives 0xAAAA.
  - Repeat with wea=10, web=01 -> 0xAA55.
  - B reading addr 9 while A writes it -> dob shows old data.
- Output register: OUT_REG=1, B reads addr 7 (holding 0x0F0F) at edge k -> dob=0x0F0F and vldb=1 after edge k+1 only; enb=0 afterwards -> vldb=0, dob holds.
- Reset mid-stream: read burst in flight, pulse rst_n low between edges -> doa/dob/vld/coll go to 0 immediately. A write asserted during reset leaves memory unchanged. Reads after release return pre-reset contents.

Source files
------------

// File: rtl/v_rams_pkg.sv
// Shared constants and helpers for the byte-enable dual-port RAM.
package v_rams_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   function automatic int calc_nb(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/v_rams_oreg.sv
// Optional per-port output stage: registers data and valid when OUT_REG=1, bypasses otherwise.
module v_rams_oreg #(
   parameter int DATA_W  = 16,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d,
   input  logic              v,
   output logic [DATA_W-1:0] q,
   output logic              vq
);

   logic [DATA_W-1:0] d_r;
   logic              v_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_r <= '0;
         v_r <= 1'b0;
      end else begin
         d_r <= d;
         v_r <= v;
      end
   end

   assign q  = (OUT_REG != 0) ? d_r : d;
   assign vq = (OUT_REG != 0) ? v_r : v;

endmodule

// File: rtl/v_rams_dp_be.sv
// True dual-port single-clock RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and collision flag.
module v_rams_dp_be
   import v_rams_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int BYTE_W     = 8,
   parameter int ADDR_W     = 6,
   parameter int WRITE_MODE = WM_READ_FIRST,
   parameter int OUT_REG    = 0,
   localparam int NB        = calc_nb(DATA_W, BYTE_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NB-1:0]     wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dia,
   output logic [DATA_W-1:0] doa,
   output logic              vlda,
   input  logic              enb,
   input  logic [NB-1:0]     web,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dib,
   output logic [DATA_W-1:0] dob,
   output logic              vldb,
   output logic              coll
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (DATA_W % BYTE_W != 0) begin : g_bad_width
      $error("v_rams_dp_be: DATA_W must be a multiple of BYTE_W");
   end
   if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_mode
      $error("v_rams_dp_be: WRITE_MODE must be 0, 1 or 2");
   end

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NB-1:0]     wr_a, wr_b;
   logic              same_addr;
   logic [DATA_W-1:0] old_a, old_b;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic              launch_a, launch_b;
   logic              coll_d;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic              vld_a1, vld_b1;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
      return r;
   endfunction

   always_comb begin
      wr_a      = ena ? wea : '0;
      wr_b      = enb ? web : '0;
      same_addr = (addra == addrb);
      old_a     = mem[addra];
      old_b     = mem[addrb];
      // NO_CHANGE suppresses the read launch entirely when the port writes.
      launch_a  = ena && !((WRITE_MODE == WM_NO_CHANGE) && (|wea));
      launch_b  = enb && !((WRITE_MODE == WM_NO_CHANGE) && (|web));
      rdata_a   = (WRITE_MODE == WM_WRITE_FIRST) ? merge_lanes(old_a, dia, wea) : old_a;
      rdata_b   = (WRITE_MODE == WM_WRITE_FIRST) ? merge_lanes(old_b, dib, web) : old_b;
      coll_d    = ena && enb && same_addr && ((|wea) || (|web));
   end

   // Port A wins any lane both ports write at the same address.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b[i] && !(wr_a[i] && same_addr))
               mem[addrb][i*BYTE_W +: BYTE_W] <= dib[i*BYTE_W +: BYTE_W];
            if (wr_a[i])
               mem[addra][i*BYTE_W +: BYTE_W] <= dia[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // vld marks the cycle holding freshly launched read data; data holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_a   <= '0;
         rd_b   <= '0;
         vld_a1 <= 1'b0;
         vld_b1 <= 1'b0;
         coll   <= 1'b0;
      end else begin
         if (launch_a) rd_a <= rdata_a;
         if (launch_b) rd_b <= rdata_b;
         vld_a1 <= launch_a;
         vld_b1 <= launch_b;
         coll   <= coll_d;
      end
   end

   v_rams_oreg #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_oreg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rd_a),
      .v     (vld_a1),
      .q     (doa),
      .vq    (vlda)
   );

   v_rams_oreg #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_oreg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rd_b),
      .v     (vld_b1),
      .q     (dob),
      .vq    (vldb)
   );

endmodule

// File: tb/tb_v_rams_dp_be.sv
// Bench for v_rams_dp_be: four configurations driven in parallel, checked against a word-level model.
module tb_v_rams_dp_be;

   localparam int N = 4;
   localparam int MODE [N] = '{0, 1, 2, 0};
   localparam int OREG [N] = '{0, 0, 0, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0, enb = 1'b0;
   logic [1:0]  wea = '0, web = '0;
   logic [5:0]  addra = '0, addrb = '0;
   logic [15:0] dia = '0, dib = '0;

   logic [15:0] doa_w [N];
   logic [15:0] dob_w [N];
   logic        vlda_w [N];
   logic        vldb_w [N];
   logic        coll_w [N];

   int checks = 0;
   int errors = 0;

   logic [15:0] mem_m [64];
   logic [15:0] s1_da [N], s1_db [N], exp_doa [N], exp_dob [N];
   logic        s1_va [N], s1_vb [N], exp_vlda [N], exp_vldb [N];
   logic        exp_coll;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      v_rams_dp_be #(
         .DATA_W(16), .BYTE_W(8), .ADDR_W(6),
         .WRITE_MODE(MODE[g]), .OUT_REG(OREG[g])
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa_w[g]), .vlda(vlda_w[g]),
         .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob_w[g]), .vldb(vldb_w[g]),
         .coll(coll_w[g])
      );
   end

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] w);
      logic [15:0] r;
      r = old;
      for (int i = 0; i < 2; i++) if (w[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < N; d++) begin
         s1_da[d] = '0; s1_db[d] = '0; s1_va[d] = 1'b0; s1_vb[d] = 1'b0;
         exp_doa[d] = '0; exp_dob[d] = '0; exp_vlda[d] = 1'b0; exp_vldb[d] = 1'b0;
      end
      exp_coll = 1'b0;
   endtask

   // Reference behaviour of one rising edge, using the values the bench is driving.
   task automatic model_edge();
      logic [15:0] olda, oldb, na, nb;
      logic        va, vb;
      if (!rst_n) begin
         model_clear();
         return;
      end
      olda = mem_m[addra];
      oldb = mem_m[addrb];
      for (int d = 0; d < N; d++) begin
         va = ena && !(MODE[d] == 2 && wea != 0);
         vb = enb && !(MODE[d] == 2 && web != 0);
         na = !va ? s1_da[d] : (MODE[d] == 1 ? merge(olda, dia, wea) : olda);
         nb = !vb ? s1_db[d] : (MODE[d] == 1 ? merge(oldb, dib, web) : oldb);
         if (OREG[d] != 0) begin
            exp_doa[d] = s1_da[d]; exp_vlda[d] = s1_va[d];
            exp_dob[d] = s1_db[d]; exp_vldb[d] = s1_vb[d];
         end else begin
            exp_doa[d] = na; exp_vlda[d] = va;
            exp_dob[d] = nb; exp_vldb[d] = vb;
         end
         s1_da[d] = na; s1_va[d] = va; s1_db[d] = nb; s1_vb[d] = vb;
      end
      exp_coll = ena && enb && (addra == addrb) && (wea != 0 || web != 0);
      // B first, then A, so A owns any shared lane.
      if (enb) mem_m[addrb] = merge(mem_m[addrb], dib, web);
      if (ena) mem_m[addra] = merge(mem_m[addra], dia, wea);
   endtask

   task automatic step(input logic ea, input logic [1:0] wa, input logic [5:0] aa,
                       input logic [15:0] da, input logic eb, input logic [1:0] wb,
                       input logic [5:0] ab, input logic [15:0] db);
      @(negedge clk);
      ena = ea; wea = wa; addra = aa; dia = da;
      enb = eb; web = wb; addrb = ab; dib = db;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < N; d++) begin
         checks++;
         if ({doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]} !== 35'd0) begin
            errors++;
            $display("FAIL reset inst%0d doa=%h vlda=%b dob=%h vldb=%b coll=%b required all 0",
                     d, doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_init();
      for (int a = 0; a < 32; a++)
         step(1'b1, 2'b11, 6'(a), 16'($urandom), 1'b1, 2'b11, 6'(a + 32), 16'($urandom));
      step(1'b1, 2'b00, 6'd0, 16'h0, 1'b1, 2'b00, 6'd1, 16'h0);
      step(1'b1, 2'b00, 6'd2, 16'h0, 1'b1, 2'b00, 6'd3, 16'h0);
      for (int d = 0; d < N; d++) begin
         checks++;
         if ({doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]} !==
             {exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll}) begin
            errors++;
            $display("FAIL init inst%0d got %h/%b %h/%b %b required %h/%b %h/%b %b", d,
                     doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d],
                     exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll);
         end
      end
   endtask

   task automatic test_byte_write();
      step(1'b1, 2'b11, 6'd5, 16'hBEEF, 1'b0, 2'b00, 6'd0, 16'h0);
      step(1'b1, 2'b01, 6'd5, 16'h0012, 1'b0, 2'b00, 6'd0, 16'h0);
      step(1'b1, 2'b00, 6'd5, 16'h0000, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (doa_w[0] !== 16'hBE12 || vlda_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL byte_write doa=%h vlda=%b required BE12/1", doa_w[0], vlda_w[0]);
      end
      for (int d = 0; d < N; d++) begin
         checks++;
         if ({doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]} !==
             {exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll}) begin
            errors++;
            $display("FAIL byte_write_model inst%0d got %h/%b %h/%b %b required %h/%b %h/%b %b", d,
                     doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d],
                     exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll);
         end
      end
   endtask

   task automatic test_rdw_modes();
      logic [15:0] held;
      step(1'b1, 2'b11, 6'd3, 16'h1111, 1'b0, 2'b00, 6'd0, 16'h0);
      held = exp_doa[2];
      step(1'b1, 2'b11, 6'd3, 16'h2222, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (doa_w[0] !== 16'h1111 || vlda_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL rdw_read_first doa=%h vlda=%b required 1111/1", doa_w[0], vlda_w[0]);
      end
      checks++;
      if (doa_w[1] !== 16'h2222 || vlda_w[1] !== 1'b1) begin
         errors++;
         $display("FAIL rdw_write_first doa=%h vlda=%b required 2222/1", doa_w[1], vlda_w[1]);
      end
      checks++;
      if (doa_w[2] !== held || vlda_w[2] !== 1'b0) begin
         errors++;
         $display("FAIL rdw_no_change doa=%h vlda=%b required %h/0", doa_w[2], vlda_w[2], held);
      end
      step(1'b1, 2'b00, 6'd3, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (doa_w[d] !== 16'h2222 || vlda_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL rdw_next_read inst%0d doa=%h vlda=%b required 2222/1", d, doa_w[d], vlda_w[d]);
         end
      end
   endtask

   task automatic test_collision();
      step(1'b1, 2'b11, 6'd9, 16'hAAAA, 1'b1, 2'b11, 6'd9, 16'h5555);
      for (int d = 0; d < N; d++) begin
         checks++;
         if (coll_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL coll_full inst%0d coll=%b required 1", d, coll_w[d]);
         end
      end
      step(1'b1, 2'b00, 6'd9, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (doa_w[0] !== 16'hAAAA || coll_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL coll_a_wins doa=%h coll=%b required AAAA/0", doa_w[0], coll_w[0]);
      end
      step(1'b1, 2'b10, 6'd9, 16'hAAAA, 1'b1, 2'b01, 6'd9, 16'h5555);
      checks++;
      if (coll_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_split coll=%b required 1", coll_w[0]);
      end
      step(1'b1, 2'b00, 6'd9, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (doa_w[0] !== 16'hAA55) begin
         errors++;
         $display("FAIL coll_merge doa=%h required AA55", doa_w[0]);
      end
      step(1'b1, 2'b11, 6'd9, 16'h1234, 1'b1, 2'b00, 6'd9, 16'h0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (dob_w[d] !== 16'hAA55 || vldb_w[d] !== 1'b1 || coll_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL coll_cross_read inst%0d dob=%h vldb=%b coll=%b required AA55/1/1",
                     d, dob_w[d], vldb_w[d], coll_w[d]);
         end
      end
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, 2'b00, 6'd9, 16'h0);
      checks++;
      if (dob_w[0] !== 16'h1234 || coll_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL coll_after dob=%h coll=%b required 1234/0", dob_w[0], coll_w[0]);
      end
   endtask

   task automatic test_out_reg();
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, 2'b11, 6'd7, 16'h0F0F);
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, 2'b00, 6'd7, 16'h0);
      checks++;
      if (vldb_w[3] !== 1'b0) begin
         errors++;
         $display("FAIL oreg_edge_k vldb=%b required 0", vldb_w[3]);
      end
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (dob_w[3] !== 16'h0F0F || vldb_w[3] !== 1'b1) begin
         errors++;
         $display("FAIL oreg_edge_k1 dob=%h vldb=%b required 0F0F/1", dob_w[3], vldb_w[3]);
      end
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (dob_w[3] !== 16'h0F0F || vldb_w[3] !== 1'b0) begin
         errors++;
         $display("FAIL oreg_hold dob=%h vldb=%b required 0F0F/0", dob_w[3], vldb_w[3]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom), 2'($urandom), 6'($urandom_range(0, 15)), 16'($urandom),
              1'($urandom), 2'($urandom), 6'($urandom_range(0, 15)), 16'($urandom));
         for (int d = 0; d < N; d++) begin
            checks++;
            if ({doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]} !==
                {exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll}) begin
               errors++;
               $display("FAIL random n%0d inst%0d got %h/%b %h/%b %b required %h/%b %h/%b %b", n, d,
                        doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d],
                        exp_doa[d], exp_vlda[d], exp_dob[d], exp_vldb[d], exp_coll);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] keep5, keep6;
      keep5 = mem_m[5];
      keep6 = mem_m[6];
      step(1'b1, 2'b00, 6'd5, 16'h0, 1'b1, 2'b00, 6'd6, 16'h0);
      step(1'b1, 2'b00, 6'd6, 16'h0, 1'b1, 2'b00, 6'd5, 16'h0);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      for (int d = 0; d < N; d++) begin
         checks++;
         if ({doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_async inst%0d doa=%h vlda=%b dob=%h vldb=%b coll=%b required all 0",
                     d, doa_w[d], vlda_w[d], dob_w[d], vldb_w[d], coll_w[d]);
         end
      end
      step(1'b1, 2'b11, 6'd5, 16'hFFFF, 1'b1, 2'b11, 6'd6, 16'hEEEE);
      rst_n = 1'b1;
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      for (int d = 0; d < N; d++) begin
         checks++;
         if (vlda_w[d] !== 1'b0 || vldb_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_stale inst%0d vlda=%b vldb=%b required 0/0", d, vlda_w[d], vldb_w[d]);
         end
      end
      step(1'b1, 2'b00, 6'd5, 16'h0, 1'b1, 2'b00, 6'd6, 16'h0);
      checks++;
      if (doa_w[0] !== keep5 || dob_w[0] !== keep6 || vlda_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_contents doa=%h dob=%h vlda=%b required %h %h 1",
                  doa_w[0], dob_w[0], vlda_w[0], keep5, keep6);
      end
      step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
      checks++;
      if (dob_w[3] !== keep6 || vldb_w[3] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_oreg dob=%h vldb=%b required %h/1", dob_w[3], vldb_w[3], keep6);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_byte_write();
      test_rdw_modes();
      test_collision();
      test_out_reg();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
